// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serial write engine for the board DAC and three reference DACs.
// Takes one DATA_W-bit command plus a 2-bit target select through a valid/ready
// handshake and shifts it out MSB-first in SPI mode 0 (sclk idles low, slave
// samples on the rising edge) with the selected chip-select held low.
// Optional feature: define DAC_SPI_LDAC_EN to add the ldac_n port and a
// post-frame load-strobe state; done then follows the end of the strobe.
module dac_spi_tx #(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2,
    parameter int LDAC_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [1:0]        cmd_sel,
    output logic              sdi,
    output logic              sclk,
    output logic [3:0]        cs_n,
    output logic              busy,
`ifdef DAC_SPI_LDAC_EN
    output logic              ldac_n,
`endif
    output logic              done
);

    // One shared cycle counter times every phase, so it must hold the longest one.
    localparam int MAX_A   = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CNT = (MAX_C > LDAC_W) ? MAX_C : LDAC_W;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
`ifdef DAC_SPI_LDAC_EN
    localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_W - 1);
`endif
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
`ifdef DAC_SPI_LDAC_EN
        , ST_LDAC
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [1:0]          sel_q, sel_d;
    logic                sdi_d, sclk_d, busy_d, done_d;
    logic [3:0]          cs_n_d;
`ifdef DAC_SPI_LDAC_EN
    logic                ldac_n_d;
`endif

    assign cmd_ready = (state_q == ST_IDLE);

    // Next-state logic plus next values of the pins, computed from the next
    // state so every pin can be a plain flop with no path from cmd_* to the pad.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        sel_d   = sel_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    shreg_d = cmd_data;
                    sel_d   = cmd_sel;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = BIT_LAST;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == '0) begin
                        state_d = ST_HOLD;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q - 1'b1;
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
`ifdef DAC_SPI_LDAC_EN
                    state_d = ST_LDAC;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef DAC_SPI_LDAC_EN
            ST_LDAC: begin
                if (cnt_q == LDAC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        sdi_d  = 1'b0;
        sclk_d = 1'b0;
        cs_n_d = 4'b1111;
        busy_d = (state_d != ST_IDLE);
`ifdef DAC_SPI_LDAC_EN
        ldac_n_d = (state_d != ST_LDAC);
        done_d   = (state_q == ST_LDAC) && (state_d == ST_IDLE);
`else
        done_d   = (state_q == ST_HOLD) && (state_d == ST_GAP);
`endif
        if ((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD)) begin
            cs_n_d = ~(4'b0001 << sel_d);
            sdi_d  = shreg_d[DATA_W-1];
            sclk_d = (state_d == ST_SHIFT) && phase_d;
        end
    end

    // State, counters, captured command and registered pins; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
            sel_q   <= '0;
            sdi     <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= 4'b1111;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
            ldac_n  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            sel_q   <= sel_d;
            sdi     <= sdi_d;
            sclk    <= sclk_d;
            cs_n    <= cs_n_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef DAC_SPI_LDAC_EN
            ldac_n  <= ldac_n_d;
`endif
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx. Commands are pushed to a
// queue at acceptance; a bus monitor rebuilds each SPI frame from the pins and
// pops the queue when chip-select returns high.
module tb_dac_spi_tx;

    localparam int DATA_W   = 16;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 2;
    localparam int LDAC_W   = 2;
    localparam int CS_LOW   = CS_SETUP + 2 * CLK_DIV * DATA_W + CS_HOLD;
`ifdef DAC_SPI_LDAC_EN
    localparam int DONE_OFF = CS_GAP + LDAC_W;
`else
    localparam int DONE_OFF = 0;
`endif
    localparam int B2B_GAP  = CS_GAP + 1 + DONE_OFF - ((DONE_OFF == 0) ? 0 : CS_GAP);
    localparam int PERIOD   = CS_LOW + B2B_GAP;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [1:0]        cmd_sel = '0;
    logic              sdi, sclk, busy, done;
    logic [3:0]        cs_n;
`ifdef DAC_SPI_LDAC_EN
    logic              ldac_n;
`endif

    int test_count = 0;
    int fail_count = 0;

    logic [17:0] sb_q[$];
    int          done_cycles[$];
    int          r_hist[$];
    int          start_hist[$];

    int          cycle = 0;
    bit          in_frame = 0;
    int          low_cnt, bits, r_cycle = -1000, done_count = 0;
    logic [15:0] shift_word;
    logic [3:0]  frame_cs;
    bit          cs_changed, sclk_stray = 0;
    logic        prev_sclk = 1'b0;
    logic        ldac_prev = 1'b1;
    int          ldac_len = 0;

    dac_spi_tx #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .LDAC_W(LDAC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .cmd_sel(cmd_sel),
        .sdi(sdi),
        .sclk(sclk),
        .cs_n(cs_n),
        .busy(busy),
`ifdef DAC_SPI_LDAC_EN
        .ldac_n(ldac_n),
`endif
        .done(done)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Bus monitor: rebuilds frames from the pins on the falling edge and scores them
    always @(negedge clk) begin
        logic [17:0] exp_word;
        logic [3:0]  exp_cs;
        cycle++;
        if (rst) begin
            in_frame  = 0;
            prev_sclk = 1'b0;
            ldac_prev = 1'b1;
            ldac_len  = 0;
        end else begin
            if (!in_frame && cs_n != 4'b1111) begin
                in_frame   = 1;
                frame_cs   = cs_n;
                low_cnt    = 0;
                bits       = 0;
                shift_word = '0;
                cs_changed = 0;
                start_hist.push_back(cycle);
            end
            if (in_frame) begin
                if (cs_n == 4'b1111) begin
                    in_frame = 0;
                    r_cycle  = cycle;
                    r_hist.push_back(cycle);
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_frame", 1, 0);
                    end else begin
                        exp_word = sb_q.pop_front();
                        exp_cs   = ~(4'b0001 << exp_word[17:16]);
                        checkOutput("frame_data", shift_word, exp_word[15:0]);
                        checkOutput("frame_cs", frame_cs, exp_cs);
                        checkOutput("frame_bits", bits, DATA_W);
                        checkOutput("cs_low_cycles", low_cnt, CS_LOW);
                        checkOutput("cs_stable", cs_changed, 0);
                    end
                end else begin
                    low_cnt++;
                    if (cs_n != frame_cs) cs_changed = 1;
                    if (sclk && !prev_sclk) begin
                        shift_word = {shift_word[14:0], sdi};
                        bits++;
                    end
                end
            end else if (sclk) begin
                sclk_stray = 1;
            end
            if (done) begin
                done_count++;
                done_cycles.push_back(cycle);
                checkOutput("done_offset", cycle - r_cycle, DONE_OFF);
            end
`ifdef DAC_SPI_LDAC_EN
            if (!ldac_n) begin
                if (ldac_prev) checkOutput("ldac_start", cycle - r_cycle, CS_GAP);
                ldac_len++;
            end else if (!ldac_prev) begin
                checkOutput("ldac_width", ldac_len, LDAC_W);
                ldac_len = 0;
            end
            ldac_prev = ldac_n;
`endif
            prev_sclk = sclk;
        end
    end

    // Offer one command, wait (bounded) for acceptance and record it in the scoreboard
    task automatic applyStimulus(input logic [15:0] data, input logic [1:0] sel, input bit hold);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("accept_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_sel   = sel;
        @(posedge clk);
        sb_q.push_back({sel, data});
        #1;
        cmd_data = ~data;
        cmd_sel  = sel + 2'd1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((in_frame || !cmd_ready || sb_q.size() != 0) && n < 3000);
        checkOutput("idle_reached", n < 3000, 1);
    endtask

    // Main sequence
    initial begin
        int n0, ds, rs, ss, base_done, waited;

        #2 rst = 1'b1;
        #1;
        checkOutput("rst_sdi", sdi, 0);
        checkOutput("rst_sclk", sclk, 0);
        checkOutput("rst_cs_n", cs_n, 4'b1111);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", cmd_ready, 1);

        applyStimulus(16'hA5C3, 2'd0, 0);
        @(negedge clk);
        checkOutput("busy_in_frame", busy, 1);
        checkOutput("ready_in_frame", cmd_ready, 0);
        waitIdle();

        applyStimulus(16'h0001, 2'd3, 0);
        waitIdle();

        n0 = done_cycles.size();
        applyStimulus(16'h1234, 2'd1, 1);
        applyStimulus(16'hFFFF, 2'd2, 0);
        waitIdle();
        ds = done_cycles.size();
        rs = r_hist.size();
        ss = start_hist.size();
        checkOutput("b2b_done_count", ds - n0, 2);
        if (ds >= 2 && rs >= 2 && ss >= 1) begin
            checkOutput("b2b_done_period", done_cycles[ds-1] - done_cycles[ds-2], PERIOD);
            checkOutput("b2b_cs_gap", start_hist[ss-1] - r_hist[rs-2], B2B_GAP);
        end

        applyStimulus(16'h5A5A, 2'd2, 0);
        waited = 0;
        while (bits != 8 && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("reached_bit7", bits, 8);
        repeat (5) @(negedge clk);
        base_done = done_count;
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_cs_n", cs_n, 4'b1111);
        checkOutput("midrst_sclk", sclk, 0);
        checkOutput("midrst_sdi", sdi, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (CS_LOW + 10) @(negedge clk);
        #1;
        checkOutput("midrst_no_done", done_count, base_done);
        checkOutput("midrst_ready", cmd_ready, 1);

        applyStimulus(16'h0F0F, 2'd1, 0);
        waitIdle();
        repeat (10) @(negedge clk);

        checkOutput("total_done", done_count, 5);
        checkOutput("sclk_outside_cs", sclk_stray, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial write engine for the board's DAC and three reference DACs. It accepts one 16-bit command word plus a target select through a valid/ready handshake. It then shifts the word MSB-first in SPI mode 0 on a shared data/clock pair, driving the chip-select of the selected device. It sits between the control/sequencing logic and the DAC and reference-DAC pins (CS_DAC, CS_REF1..3, SDI/CLK lines).

## Interface
- DATA_W, 16, bits per frame (MSB first)
- CLK_DIV, 4, clk cycles per sclk half-period (≥1)
- CS_SETUP, 2, cycles cs_n low before the first sclk low phase (≥1)
- CS_HOLD, 2, cycles cs_n stays low after the last sclk high phase (≥1)
- CS_GAP, 2, cycles all cs_n stay high before cmd_ready returns (≥1)
- LDAC_W, 2, ldac_n low-pulse width; used only when DAC_SPI_LDAC_EN is defined

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle; a command is accepted on a clk edge with cmd_valid && cmd_ready
- cmd_data  in  DATA_W  word to send; captured at acceptance
- cmd_sel  in  2  target: 0=DAC, 1=REF1, 2=REF2, 3=REF3
- sdi  out  1  serial data
- sclk  out  1  serial clock, idles low
- cs_n  out  4  active-low chip selects, indexed by cmd_sel
- busy  out  1  high from acceptance until cmd_ready returns
- done  out  1  one-cycle pulse at frame completion
- ldac_n  out  1  load strobe, active-low; present only with DAC_SPI_LDAC_EN

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → (LDAC when enabled) → IDLE.
- IDLE: cmd_ready=1 (decoded from state), busy=0. On acceptance, the engine latches cmd_data into a shift register and cmd_sel into a select register, then enters SETUP.
- SETUP: cs_n[sel]=0 and the other three stay 1. sdi = data[DATA_W-1]. sclk=0. Lasts CS_SETUP cycles.
- SHIFT: DATA_W bits. Each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - sdi updates only at the start of a low phase, so the first bit is already valid from SETUP.
  - The slave samples on the sclk rising edge.
  - A bit counter counts DATA_W-1 down to 0; a divider counter times the half-periods.
- HOLD: sclk=0, cs_n[sel] still low, sdi holds the LSB. Lasts CS_HOLD cycles.
- GAP: all cs_n=1, sdi=0. Lasts CS_GAP cycles.
- cmd_data and cmd_sel changes after acceptance have no effect. cmd_valid while busy is ignored.
- Exactly one cs_n bit is ever low; sclk toggles only while a cs_n bit is low.
- Reset value of every output: sdi=0, sclk=0, cs_n=4'b1111, busy=0, done=0, ldac_n=1. cmd_ready=1 after reset.
- Reset mid-frame: all outputs return to reset values asynchronously, the frame is aborted with no done pulse, and the engine restarts in IDLE.

## Timing
- Let A be the clk edge where a command is accepted. cs_n[sel] falls and busy rises in the cycle after A.
- cs_n low duration: CS_SETUP + 2·CLK_DIV·DATA_W + CS_HOLD cycles. With defaults: 2+128+2 = 132.
- First sclk rising edge: CS_SETUP + CLK_DIV cycles after cs_n falls (6 with defaults).
- Let R be the first cycle with cs_n all high. Without LDAC, done=1 in cycle R only, and cmd_ready=1 from cycle R+CS_GAP.
- Back-to-back: with cmd_valid held, the next cs_n fall is at R+CS_GAP+1. Minimum cs_n high time is therefore CS_GAP+1 cycles.
- Period per command (defaults, no LDAC): 132 + 3 = 135 cycles.
- All outputs are registered; no combinational path from cmd_* to the pins.

## Configuration
- DAC_SPI_LDAC_EN defined:
  - The ldac_n port and LDAC state exist.
  - After GAP, ldac_n is driven low for LDAC_W cycles starting at R+CS_GAP.
  - done pulses in the first cycle after ldac_n returns high; cmd_ready=1 from R+CS_GAP+LDAC_W.
- DAC_SPI_LDAC_EN undefined: no ldac_n port, no LDAC state, and timing is as in Timing.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> sdi=0, sclk=0, cs_n=4'b1111, busy=0, done=0 immediately; cmd_ready=1 after release.
- Single write, sel=0, data=0xA5C3, defaults:
  - cs_n=4'b1110 for exactly 132 cycles.
  - 16 sclk rises, sampled sdi = 1010_0101_1100_0011.
  - One done pulse at R.
- sel=3, data=0x0001 -> only cs_n[3] low; sdi=0 at the first 15 rises and 1 at the 16th; cs_n[2:0] stay 1.
- Back-to-back: cmd_valid held high with 0x1234/sel=1, then 0xFFFF/sel=2; cmd_data changed mid-frame.
  - First frame intact.
  - Second cs_n falls at R+3.
  - Two done pulses, 135 cycles apart.
- Reset during bit 7 of the SHIFT state -> cs_n all high and sclk=0 at once, no done pulse; the next command produces a full 132-cycle frame.
- With DAC_SPI_LDAC_EN, data=0x8000:
  - ldac_n low exactly in cycles R+2..R+3.
  - done at R+4, cmd_ready=1 at R+4.
